cpu_clock_controller: RTL and testbench

//  Run/single-step/halt control for the processor clock. Sits directly downstream of the

---
 rtl/cpu_clock_controller.sv | 177 +++++++++++++++++
 tb/tb_cpu_clock_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
// Run / single-step / halt control for the processor clock. A free-running
// divider produces a tick every DIVIDER cycles; the mode FSM decides whether
// a tick becomes a one-cycle clock-enable pulse for the core. Delivered
// pulses are counted in out_cycle_count.
//
// Handshake note: there is no valid/ready pair on this block. out_clk_en is a
// registered single-cycle strobe; the core must act on every cycle in which
// it is high. in_halt is a level sampled on every in_clk edge.
module cpu_clock_controller #(
  parameter int DIVIDER  = 4,
  parameter int DEBOUNCE = 16,
  parameter int COUNT_W  = 32
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               in_run,
  input  logic               in_step,
  input  logic               in_halt,
  output logic               out_clk_en,
  output logic [1:0]         out_state,
  output logic [COUNT_W-1:0] out_cycle_count
);

  localparam int TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  // Divider
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  // Synchronisers
  logic r_run_meta;
  logic r_run_s;
  logic r_step_meta;
  logic r_step_s;

  // Debounce
  logic [DW-1:0] r_db_cnt;
  logic          r_step_db;
  logic          r_step_req;
  logic          w_step_diff;
  logic          w_db_hit;

  // Mode control
  state_t               r_state;
  state_t               w_state_next;
  logic                 r_step_pend;
  logic                 w_step_pend_next;
  logic                 r_clk_en;
  logic                 w_clk_en_next;
  logic [COUNT_W-1:0]   r_cycle_count;

  assign w_tick = (r_tick_cnt == TW'(DIVIDER - 1));

  // Tick counter: free-running, never restarted by mode changes.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Two-flop synchronisers for the asynchronous run switch and step button.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_run_meta  <= 1'b0;
      r_run_s     <= 1'b0;
      r_step_meta <= 1'b0;
      r_step_s    <= 1'b0;
    end else begin
      r_run_meta  <= in_run;
      r_run_s     <= r_run_meta;
      r_step_meta <= in_step;
      r_step_s    <= r_step_meta;
    end
  end

  // The level flips on the DEBOUNCE-th consecutive sample that disagrees with it.
  assign w_step_diff = r_step_s ^ r_step_db;
  assign w_db_hit    = w_step_diff && (r_db_cnt == DW'(DEBOUNCE - 1));

  // Debounce counter, debounced level and its one-cycle rising-edge request.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_db_cnt   <= '0;
      r_step_db  <= 1'b0;
      r_step_req <= 1'b0;
    end else begin
      if (!w_step_diff || w_db_hit) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (w_db_hit) begin
        r_step_db <= ~r_step_db;
      end
      r_step_req <= w_db_hit & ~r_step_db;
    end
  end

  // Next state, pending-step bookkeeping and the next clock-enable value.
  always_comb begin
    w_state_next     = r_state;
    w_step_pend_next = r_step_pend;
    w_clk_en_next    = w_tick & (((r_state == S_RUN) & r_run_s & ~in_halt) |
                                 (r_state == S_STEP));
    case (r_state)
      S_IDLE: begin
        if (r_run_s) begin
          // Run wins; any pending step is thrown away.
          w_state_next     = S_RUN;
          w_step_pend_next = 1'b0;
        end else if (r_step_pend) begin
          // Pending step consumed; a simultaneous request is dropped.
          w_state_next     = S_STEP;
          w_step_pend_next = 1'b0;
        end else if (r_step_req) begin
          w_step_pend_next = 1'b1;
        end
      end
      S_RUN: begin
        if (in_halt) begin
          w_state_next = S_HALTED;
        end else if (!r_run_s) begin
          w_state_next = S_IDLE;
        end
      end
      S_STEP: begin
        if (w_tick) begin
          w_state_next = in_halt ? S_HALTED : S_IDLE;
        end
        if (r_step_req) begin
          w_step_pend_next = 1'b1;
        end
      end
      S_HALTED: begin
        if (!r_run_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register, pending flag, registered clock-enable and cycle counter.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state       <= S_IDLE;
      r_step_pend   <= 1'b0;
      r_clk_en      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_step_pend   <= w_step_pend_next;
      r_clk_en      <= w_clk_en_next;
      r_cycle_count <= r_cycle_count + COUNT_W'(r_clk_en);
    end
  end

  assign out_clk_en      = r_clk_en;
  assign out_state       = r_state;
  assign out_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller. Two instances share the same inputs:
// u_a (DIVIDER=4, DEBOUNCE=4, COUNT_W=4) and u_b (DIVIDER=1, DEBOUNCE=2,
// COUNT_W=8). A behavioural model predicts state, pulse and count for both.
module tb_cpu_clock_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  logic step = 1'b0;
  logic halt = 1'b0;

  always #5 clk = ~clk;

  logic       en_a;
  logic [1:0] st_a;
  logic [3:0] cnt_a;
  logic       en_b;
  logic [1:0] st_b;
  logic [7:0] cnt_b;

  cpu_clock_controller #(.DIVIDER(4), .DEBOUNCE(4), .COUNT_W(4)) u_a (
    .in_clk(clk), .in_rst_n(rst_n), .in_run(run), .in_step(step), .in_halt(halt),
    .out_clk_en(en_a), .out_state(st_a), .out_cycle_count(cnt_a)
  );

  cpu_clock_controller #(.DIVIDER(1), .DEBOUNCE(2), .COUNT_W(8)) u_b (
    .in_clk(clk), .in_rst_n(rst_n), .in_run(run), .in_step(step), .in_halt(halt),
    .out_clk_en(en_b), .out_state(st_b), .out_cycle_count(cnt_b)
  );

  // ---------------- scoreboard counters / check ----------------
  int n_vec = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode codes as they appear on out_state.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  int m_div[2] = '{4, 1};
  int m_deb[2] = '{4, 2};
  int m_mod[2] = '{16, 256};

  int m_cyc[2];      // edges since reset: tick when cyc % DIVIDER == DIVIDER-1
  int run_hist[2][2]; // in_run seen one and two edges ago
  int step_hist[2][2];
  int m_lvl[2];      // debounced button level
  int m_same[2];     // consecutive samples disagreeing with m_lvl
  int m_req[2];
  int m_pend[2];
  int m_st[2];
  int m_en[2];
  int m_cnt[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 0; m_lvl[k] = 0; m_same[k] = 0; m_req[k] = 0;
      m_pend[k] = 0; m_st[k] = M_IDLE; m_en[k] = 0; m_cnt[k] = 0;
      run_hist[k] = '{0, 0};
      step_hist[k] = '{0, 0};
    end
  endtask

  task automatic model_step(input int k);
    int tick, rs, ss, nst, npend, nen, h;
    tick  = ((m_cyc[k] % m_div[k]) == m_div[k] - 1) ? 1 : 0;
    rs    = run_hist[k][1];
    ss    = step_hist[k][1];
    h     = int'(halt);
    nst   = m_st[k];
    npend = m_pend[k];
    nen   = (tick == 1 && ((m_st[k] == M_RUN && rs == 1 && h == 0) || m_st[k] == M_STEP)) ? 1 : 0;
    case (m_st[k])
      M_IDLE: begin
        if (rs == 1) begin nst = M_RUN; npend = 0; end
        else if (m_pend[k] == 1) begin nst = M_STEP; npend = 0; end
        else if (m_req[k] == 1) npend = 1;
      end
      M_RUN:  if (h == 1) nst = M_HALT; else if (rs == 0) nst = M_IDLE;
      M_STEP: begin
        if (tick == 1) nst = (h == 1) ? M_HALT : M_IDLE;
        if (m_req[k] == 1) npend = 1;
      end
      default: if (rs == 0) nst = M_IDLE;
    endcase
    m_cnt[k] = (m_cnt[k] + m_en[k]) % m_mod[k];
    m_req[k] = 0;
    if (ss != m_lvl[k]) begin
      m_same[k]++;
      if (m_same[k] == m_deb[k]) begin
        m_lvl[k]  = 1 - m_lvl[k];
        m_same[k] = 0;
        m_req[k]  = m_lvl[k];
      end
    end else begin
      m_same[k] = 0;
    end
    run_hist[k][1]  = run_hist[k][0];
    run_hist[k][0]  = int'(run);
    step_hist[k][1] = step_hist[k][0];
    step_hist[k][0] = int'(step);
    m_st[k]   = nst;
    m_pend[k] = npend;
    m_en[k]   = nen;
    m_cyc[k]++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check_val("a_state", st_a, m_st[0]);
      check_val("a_clk_en", en_a, m_en[0]);
      check_val("a_count", cnt_a, m_cnt[0]);
      check_val("b_state", st_b, m_st[1]);
      check_val("b_clk_en", en_b, m_en[1]);
      check_val("b_count", cnt_b, m_cnt[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic press(input int hold, input int after);
    step = 1'b1;
    wait_cycles(hold);
    step = 1'b0;
    wait_cycles(after);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last, c0, saw, pulses, guard;

    #1 rst_n = 1'b0;
    wait_cycles(3);
    check_val("rst_a_en", en_a, 0);
    check_val("rst_a_state", st_a, 0);
    check_val("rst_a_count", cnt_a, 0);
    check_val("rst_b_en", en_b, 0);
    check_val("rst_b_count", cnt_b, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Free run: pulses 4 apart on u_a, every cycle on u_b.
    run = 1'b1;
    last = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en_a) begin
        if (last >= 0) check_val("run_gap", i - last, 4);
        last = i;
      end
      if (i >= 8) check_val("div1_every_cycle", en_b, 1);
    end
    check_val("run_state", st_a, 1);
    run = 1'b0;
    wait_cycles(8);
    check_val("idle_state", st_a, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("idle_no_pulse", en_a, 0);
    end

    // Bouncy glitches must not produce a step.
    c0 = m_cnt[0];
    repeat (6) press($urandom_range(1, 2), $urandom_range(6, 10));
    check_val("glitch_no_pulse", cnt_a, c0);

    // Clean press: exactly one pulse, visits STEP, returns to IDLE.
    c0 = m_cnt[0];
    saw = 0;
    step = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (st_a == 2'b10) saw = 1;
    end
    step = 1'b0;
    wait_cycles(20);
    check_val("step_seen", saw, 1);
    check_val("step_one_pulse", cnt_a, (c0 + 1) % 16);
    check_val("step_back_idle", st_a, 0);

    // Halt from RUN, presses ignored, release run, then a step works.
    run = 1'b1;
    wait_cycles(20);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    c0 = m_cnt[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("halt_no_pulse", en_a, 0);
    end
    check_val("halt_state", st_a, 3);
    press(12, 10);
    check_val("halt_press_ignored", cnt_a, c0);
    check_val("halt_still", st_a, 3);
    run = 1'b0;
    wait_cycles(2);
    check_val("halt_hold_2edges", st_a, 3);
    @(negedge clk);
    check_val("halt_exit_3edges", st_a, 0);
    c0 = m_cnt[0];
    press(12, 20);
    check_val("halt_then_step", cnt_a, (c0 + 1) % 16);

    // Pending step and run_s together in IDLE: RUN wins, no STEP visit.
    step = 1'b1;
    wait_cycles(5);
    run = 1'b1;
    saw = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (st_a == 2'b10) saw = 1;
    end
    check_val("simul_run", st_a, 1);
    check_val("simul_no_step", saw, 0);
    step = 1'b0;
    wait_cycles(10);
    run = 1'b0;
    wait_cycles(12);

    // Randomised mode traffic with bouncy buttons and sporadic halts.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) step = ~step;
      halt = ($urandom_range(0, 19) == 0);
    end
    halt = 1'b0;
    run = 1'b0;
    step = 1'b0;
    wait_cycles(12);

    // Count wrap on the 4-bit instance: 16 pulses bring it back to 0.
    do_reset();
    run = 1'b1;
    pulses = 0;
    guard = 0;
    while (pulses < 16 && guard < 200) begin
      @(negedge clk);
      if (en_a) pulses++;
      guard++;
    end
    check_val("wrap_pulses", pulses, 16);
    @(negedge clk);
    check_val("wrap_count_zero", cnt_a, 0);

    // Asynchronous reset in the middle of a pulse.
    guard = 0;
    @(negedge clk);
    while (!en_a && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("rst_wait_pulse", en_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_a_en", en_a, 0);
    check_val("midrst_a_state", st_a, 0);
    check_val("midrst_a_count", cnt_a, 0);
    check_val("midrst_b_en", en_b, 0);
    check_val("midrst_b_count", cnt_b, 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(10);
    check_val("post_rst_idle", st_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
